// File: rtl/watch_time_ctrl.sv
// watch_time_ctrl: BCD timekeeping with a 1 s prescaler and a
// RUN / SET_HOUR / SET_MIN edit state machine driven by key pulses.
// Everything runs on CLOCK and advances through single-cycle enables.
module watch_time_ctrl #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       MODE_P,
    input  logic       INC_P,
    output logic [7:0] HOUR_BCD,
    output logic [7:0] MIN_BCD,
    output logic [7:0] SEC_BCD,
    output logic [1:0] STATE,
    output logic       BLINK,
    output logic       SEC_TICK
);

    localparam logic [31:0] PRE_MAX  = 32'(CLK_HZ - 1);
    localparam int unsigned BL_DIV   = (CLK_HZ / 4 < 1) ? 1 : CLK_HZ / 4;
    localparam logic [31:0] BL_MAX   = 32'(BL_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pre;
    logic [31:0] bcnt;
    logic [7:0]  hour, min, sec;
    logic        blink, tick;

    // Increment a two-digit BCD value, wrapping from top back to 00.
    // Ones roll 9->0 with a carry into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Mode state register.
    always_ff @(posedge CLOCK) begin
        if (RESET)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Next mode: each MODE_P steps RUN -> SET_HOUR -> SET_MIN -> RUN.
    // The unused encoding falls back to RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (MODE_P) state_nxt = SET_HOUR;
            SET_HOUR: if (MODE_P) state_nxt = SET_MIN;
            SET_MIN:  if (MODE_P) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // Prescaler, BCD time, blink timer and tick pulse.
    // MODE_P takes priority over both the pending tick and INC_P.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pre   <= '0;
            bcnt  <= '0;
            hour  <= 8'h00;
            min   <= 8'h00;
            sec   <= 8'h00;
            blink <= 1'b1;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                RUN: begin
                    blink <= 1'b1;
                    bcnt  <= '0;
                    if (MODE_P) begin
                        // Entering SET_HOUR: seconds restart, pending second dropped.
                        sec <= 8'h00;
                        pre <= '0;
                    end else if (pre == PRE_MAX) begin
                        pre  <= '0;
                        tick <= 1'b1;
                        sec  <= bcd_inc(sec, 8'h59);
                        if (sec == 8'h59) begin
                            min <= bcd_inc(min, 8'h59);
                            if (min == 8'h59)
                                hour <= bcd_inc(hour, 8'h23);
                        end
                    end else begin
                        pre <= pre + 32'd1;
                    end
                end
                SET_HOUR, SET_MIN: begin
                    // Prescaler held at 0 so RUN restarts a full second later.
                    pre <= '0;
                    if (MODE_P) begin
                        bcnt  <= '0;
                        blink <= 1'b1;
                    end else begin
                        if (bcnt == BL_MAX) begin
                            bcnt  <= '0;
                            blink <= ~blink;
                        end else begin
                            bcnt <= bcnt + 32'd1;
                        end
                        if (INC_P) begin
                            if (state == SET_HOUR)
                                hour <= bcd_inc(hour, 8'h23);
                            else
                                min  <= bcd_inc(min, 8'h59);
                        end
                    end
                end
                default: begin
                    pre   <= '0;
                    bcnt  <= '0;
                    blink <= 1'b1;
                end
            endcase
        end
    end

    assign HOUR_BCD = hour;
    assign MIN_BCD  = min;
    assign SEC_BCD  = sec;
    assign STATE    = state;
    assign BLINK    = blink;
    assign SEC_TICK = tick;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// Self-checking bench for watch_time_ctrl (CLK_HZ = 10): directed
// scenarios plus random key traffic, all checked every cycle against a
// behavioural model of the watch kept as plain integers.
module tb_watch_time_ctrl;

    localparam int HZ  = 10;
    localparam int DIV = (HZ / 4 < 1) ? 1 : HZ / 4;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       MODE_P = 1'b0;
    logic       INC_P = 1'b0;
    logic [7:0] HOUR_BCD, MIN_BCD, SEC_BCD;
    logic [1:0] STATE;
    logic       BLINK, SEC_TICK;

    watch_time_ctrl #(.CLK_HZ(HZ)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .MODE_P(MODE_P), .INC_P(INC_P),
        .HOUR_BCD(HOUR_BCD), .MIN_BCD(MIN_BCD), .SEC_BCD(SEC_BCD),
        .STATE(STATE), .BLINK(BLINK), .SEC_TICK(SEC_TICK)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Model: time of day as integers, mode as 0/1/2, and elapsed-cycle
    // counters since the last prescaler restart and since set-mode entry.
    int m_h = 0, m_m = 0, m_s = 0, m_st = 0;
    int run_t = 0, bl_t = 0;
    bit m_tick = 0;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit m_blink();
        if (m_st == 0) return 1'b1;
        return ((bl_t / DIV) % 2) == 0;
    endfunction

    task automatic model_step(input bit r, input bit pm, input bit pi);
        int t;
        m_tick = 0;
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_st = 0; run_t = 0; bl_t = 0;
        end else if (m_st == 0) begin
            if (pm) begin
                m_st = 1; m_s = 0; run_t = 0; bl_t = 0;
            end else begin
                run_t++;
                if (run_t == HZ) begin
                    run_t = 0;
                    m_tick = 1;
                    t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
                end
            end
        end else if (pm) begin
            m_st = (m_st == 1) ? 2 : 0;
            bl_t = 0;
            run_t = 0;
        end else begin
            bl_t++;
            if (pi) begin
                if (m_st == 1) m_h = (m_h + 1) % 24;
                else           m_m = (m_m + 1) % 60;
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        if (!chk_en) return;
        chk("hour",  HOUR_BCD, bcd(m_h));
        chk("min",   MIN_BCD,  bcd(m_m));
        chk("sec",   SEC_BCD,  bcd(m_s));
        chk("state", {6'd0, STATE}, 8'(m_st));
        chk("blink", {7'd0, BLINK}, {7'd0, m_blink()});
        chk("tick",  {7'd0, SEC_TICK}, {7'd0, m_tick});
    endtask

    // One clock: drive inputs, let the edge happen, advance the model,
    // then compare at the falling edge.
    task automatic cyc(input bit r, input bit pm, input bit pi);
        RESET = r; MODE_P = pm; INC_P = pi;
        @(posedge CLOCK);
        model_step(r, pm, pi);
        @(negedge CLOCK);
        check_cycle();
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk_en = 1;
        check_cycle();
        chk("rst_sec", SEC_BCD, 8'h00);
        chk("rst_blink", {7'd0, BLINK}, 8'h01);

        // Free run for 600 cycles
        for (int i = 1; i <= 600; i++) begin
            cyc(0, 0, 0);
            if (i == 9)  chk("no_tick_9", {7'd0, SEC_TICK}, 8'h00);
            if (i == 10) begin
                chk("tick_10", {7'd0, SEC_TICK}, 8'h01);
                chk("sec_10", SEC_BCD, 8'h01);
            end
        end
        chk("min_600", MIN_BCD, 8'h01);
        chk("sec_600", SEC_BCD, 8'h00);

        // Set 23:59, run to 23:59:58, then across midnight
        cyc(0, 1, 0);
        for (int i = 0; i < 23; i++) cyc(0, 0, 1);
        cyc(0, 1, 0);
        for (int i = 0; i < 58; i++) cyc(0, 0, 1);
        cyc(0, 1, 0);
        for (int i = 0; i < 580; i++) cyc(0, 0, 0);
        chk("pre_sec58", SEC_BCD, 8'h58);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);
        chk("h_2359", HOUR_BCD, 8'h23);
        chk("m_2359", MIN_BCD, 8'h59);
        chk("s_2359", SEC_BCD, 8'h59);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);
        chk("h_mid", HOUR_BCD, 8'h00);
        chk("m_mid", MIN_BCD, 8'h00);
        chk("s_mid", SEC_BCD, 8'h00);

        // 25 hour increments, then MODE+INC together
        cyc(0, 1, 0);
        for (int i = 0; i < 25; i++) cyc(0, 0, 1);
        chk("hour_25", HOUR_BCD, 8'h01);
        cyc(0, 1, 1);
        chk("modeinc_state", {6'd0, STATE}, 8'h02);
        chk("modeinc_hour", HOUR_BCD, 8'h01);
        // Blink in SET_MIN
        chk("blink_entry", {7'd0, BLINK}, 8'h01);
        cyc(0, 0, 0);
        chk("blink_1", {7'd0, BLINK}, 8'h01);
        cyc(0, 0, 0);
        chk("blink_2", {7'd0, BLINK}, 8'h00);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("blink_4", {7'd0, BLINK}, 8'h01);
        for (int i = 0; i < 61; i++) cyc(0, 0, 1);
        chk("min_61", MIN_BCD, 8'h01);
        chk("min_61_hour", HOUR_BCD, 8'h01);

        // MODE on the tick edge at :59
        cyc(0, 1, 0);
        for (int i = 0; i < 599; i++) cyc(0, 0, 0);
        chk("sec59", SEC_BCD, 8'h59);
        cyc(0, 1, 0);
        chk("mt_state", {6'd0, STATE}, 8'h01);
        chk("mt_sec", SEC_BCD, 8'h00);
        chk("mt_min", MIN_BCD, 8'h01);
        chk("mt_tick", {7'd0, SEC_TICK}, 8'h00);

        // Reset mid-edit at 12:34 in SET_MIN
        for (int i = 0; i < 11; i++) cyc(0, 0, 1);
        cyc(0, 1, 0);
        for (int i = 0; i < 33; i++) cyc(0, 0, 1);
        chk("edit_h", HOUR_BCD, 8'h12);
        chk("edit_m", MIN_BCD, 8'h34);
        cyc(1, 0, 0);
        chk("mr_h", HOUR_BCD, 8'h00);
        chk("mr_m", MIN_BCD, 8'h00);
        chk("mr_state", {6'd0, STATE}, 8'h00);
        chk("mr_blink", {7'd0, BLINK}, 8'h01);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 0);
            if (i == 9)  chk("mr_notick", {7'd0, SEC_TICK}, 8'h00);
            if (i == 10) chk("mr_tick", {7'd0, SEC_TICK}, 8'h01);
        end

        // Random key traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 999) == 0,
                $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 30);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
